// File: rtl/bcd_tick_timer.sv
// bcd_tick_timer: four-digit BCD up/down timer stepped by a synchronized slow clock.
// Ports: clk, resetn (async, active-low), slow_clk (async data), start/stop/clear/load
//        single-cycle controls, load_value[15:0] BCD preset, mode (0 up, 1 down);
//        outputs count[15:0] BCD, running (RUN), done (DONE), tick (slow_clk rise pulse).
module bcd_tick_timer #(
    parameter int unsigned TICKS_PER_STEP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        slow_clk,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        mode,
    output logic [15:0] count,
    output logic        running,
    output logic        done,
    output logic        tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_STEP - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  pre_q, pre_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;

    // One BCD step with per-digit ripple carry (up) or borrow (down).
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic down);
        logic [15:0] r;
        logic [3:0]  d;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (down) begin
                    if (d == 4'd0) d = 4'd9;
                    else begin d = d - 4'd1; c = 1'b0; end
                end else begin
                    if (d == 4'd9) d = 4'd0;
                    else begin d = d + 4'd1; c = 1'b0; end
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    // Non-BCD digits in a preset saturate to 9.
    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    logic [15:0] term;
    logic [15:0] next_cnt;

    assign term     = mode ? 16'h0000 : 16'h9999;
    assign next_cnt = bcd_step(count_q, mode);
    assign tick     = s2_q & ~s3_q;

    always_comb begin
        s1_d = slow_clk;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        if (clear) begin
            state_d = IDLE;
            count_d = 16'h0000;
            pre_d   = 8'd0;
        end else if (load) begin
            state_d = IDLE;
            count_d = sanitize(load_value);
            pre_d   = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = (count_q == term) ? DONE : RUN;
                        pre_d   = 8'd0;
                    end
                end
                RUN: begin
                    // A stop wins over a coincident step; the prescaler is frozen too.
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (pre_q == PRE_LAST) begin
                            pre_d   = 8'd0;
                            count_d = next_cnt;
                            if (next_cnt == term) state_d = DONE;
                        end else begin
                            pre_d = pre_q + 8'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (start) state_d = (count_q == term) ? DONE : RUN;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            count_q <= 16'h0000;
            pre_q   <= 8'd0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_bcd_tick_timer.sv
// tb_bcd_tick_timer: scoreboard bench for bcd_tick_timer.
// Two instances (1 and 3 ticks per step) share stimulus, each with its own expected queue.
module tb_bcd_tick_timer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        slow_clk = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        mode = 1'b0;
    logic        sel = 1'b0;

    logic        start1, stop1, clear1, load1;
    logic        start3, stop3, clear3, load3;
    logic [15:0] count1, count3;
    logic        running1, running3, done1, done3, tick1, tick3;

    assign start1 = start & ~sel;
    assign stop1  = stop  & ~sel;
    assign clear1 = clear & ~sel;
    assign load1  = load  & ~sel;
    assign start3 = start & sel;
    assign stop3  = stop  & sel;
    assign clear3 = clear & sel;
    assign load3  = load  & sel;

    bcd_tick_timer #(.TICKS_PER_STEP(1)) u1 (
        .clk(clk), .resetn(resetn), .slow_clk(slow_clk),
        .start(start1), .stop(stop1), .clear(clear1), .load(load1),
        .load_value(load_value), .mode(mode),
        .count(count1), .running(running1), .done(done1), .tick(tick1)
    );

    bcd_tick_timer #(.TICKS_PER_STEP(3)) u3 (
        .clk(clk), .resetn(resetn), .slow_clk(slow_clk),
        .start(start3), .stop(stop3), .clear(clear3), .load(load3),
        .load_value(load_value), .mode(mode),
        .count(count3), .running(running3), .done(done3), .tick(tick3)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic        mon_en = 1'b0;
    logic [17:0] q1[$];
    logic [17:0] q3[$];
    logic [17:0] prev1, prev3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected entry: {count, running, done}.
    task automatic expect_out(input logic [15:0] c, input logic r, input logic d);
        if (sel) q3.push_back({c, r, d});
        else     q1.push_back({c, r, d});
    endtask

    // Monitor: any change of the observable outputs consumes one expected entry.
    always @(negedge clk) begin
        logic [17:0] c1, c3, e;
        c1 = {count1, running1, done1};
        c3 = {count3, running3, done3};
        if (mon_en && c1 !== prev1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL u1_unexpected: got %h expected no change", c1);
            end else begin
                e = q1.pop_front();
                if (c1 !== e) begin
                    bad++;
                    $display("FAIL u1_out: got %h expected %h", c1, e);
                end
            end
        end
        if (mon_en && c3 !== prev3) begin
            total++;
            if (q3.size() == 0) begin
                bad++;
                $display("FAIL u3_unexpected: got %h expected no change", c3);
            end else begin
                e = q3.pop_front();
                if (c3 !== e) begin
                    bad++;
                    $display("FAIL u3_out: got %h expected %h", c3, e);
                end
            end
        end
        prev1 = c1;
        prev3 = c3;
    end

    task automatic pulse(input int k);
        @(posedge clk); #1;
        case (k)
            0: start = 1'b1;
            1: stop  = 1'b1;
            2: clear = 1'b1;
            default: load = 1'b1;
        endcase
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        pulse(3);
    endtask

    // One slow_clk period of 8 clk; returns tick-high cycles of the selected DUT.
    task automatic slow_period(output int n);
        n = 0;
        @(posedge clk); #1;
        slow_clk = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (sel ? tick3 : tick1) n++;
        end
        #1 slow_clk = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (sel ? tick3 : tick1) n++;
        end
    endtask

    initial begin
        int n;
        bit hit;

        #7;
        check("rst_count", 32'(count1), 32'h0000);
        check("rst_flags", {29'd0, running1, done1, tick1}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Up count, one step per slow_clk rise.
        sel = 1'b0; mode = 1'b0;
        expect_out(16'h0008, 1'b0, 1'b0); do_load(16'h0008);
        expect_out(16'h0008, 1'b1, 1'b0); pulse(0);
        expect_out(16'h0009, 1'b1, 1'b0); slow_period(n);
        check("tick_width_a", n, 1);
        expect_out(16'h0010, 1'b1, 1'b0); slow_period(n);
        check("tick_width_b", n, 1);
        expect_out(16'h0011, 1'b1, 1'b0); slow_period(n);
        expect_out(16'h0011, 1'b0, 1'b0); pulse(1);

        // Down count to terminal.
        mode = 1'b1;
        expect_out(16'h0003, 1'b0, 1'b0); do_load(16'h0003);
        expect_out(16'h0003, 1'b1, 1'b0); pulse(0);
        expect_out(16'h0002, 1'b1, 1'b0); slow_period(n);
        expect_out(16'h0001, 1'b1, 1'b0); slow_period(n);
        expect_out(16'h0000, 1'b0, 1'b1); slow_period(n);
        pulse(0);
        slow_period(n);
        check("done_sticky", {30'd0, running1, done1}, 32'd1);

        // clear and load together: clear wins.
        load_value = 16'h1234;
        expect_out(16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1 clear = 1'b1; load = 1'b1;
        @(posedge clk); #1 clear = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);

        // Sanitized load, then start at terminal.
        mode = 1'b0;
        expect_out(16'h9995, 1'b0, 1'b0); do_load(16'hA9F5);
        expect_out(16'h9999, 1'b0, 1'b0); do_load(16'h9999);
        expect_out(16'h9999, 1'b0, 1'b1); pulse(0);
        expect_out(16'h0000, 1'b0, 1'b0); pulse(2);

        // stop coincident with step.
        expect_out(16'h0005, 1'b0, 1'b0); do_load(16'h0005);
        expect_out(16'h0005, 1'b1, 1'b0); pulse(0);
        expect_out(16'h0005, 1'b0, 1'b0);
        @(posedge clk); #1 slow_clk = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            if (tick1) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL tick_wait: got no tick expected tick within 8 cycles");
        end
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        repeat (3) @(posedge clk);
        slow_clk = 1'b0;
        repeat (5) @(posedge clk);
        check("stop_step_count", 32'(count1), 32'h0005);
        expect_out(16'h0000, 1'b0, 1'b0); pulse(2);

        // Prescaler of 3, kept across pause.
        sel = 1'b1;
        expect_out(16'h0100, 1'b0, 1'b0); do_load(16'h0100);
        expect_out(16'h0100, 1'b1, 1'b0); pulse(0);
        slow_period(n);
        check("tick_width_c", n, 1);
        slow_period(n);
        expect_out(16'h0100, 1'b0, 1'b0); pulse(1);
        slow_period(n);
        slow_period(n);
        check("pause_count", 32'(count3), 32'h0100);
        expect_out(16'h0100, 1'b1, 1'b0); pulse(0);
        expect_out(16'h0101, 1'b1, 1'b0); slow_period(n);
        slow_period(n);
        slow_period(n);
        check("pre3_mid", 32'(count3), 32'h0101);
        expect_out(16'h0102, 1'b1, 1'b0); slow_period(n);
        expect_out(16'h0000, 1'b0, 1'b0); pulse(2);

        // Asynchronous reset mid-run.
        sel = 1'b0;
        expect_out(16'h0100, 1'b0, 1'b0); do_load(16'h0100);
        expect_out(16'h0100, 1'b1, 1'b0); pulse(0);
        expect_out(16'h0101, 1'b1, 1'b0); slow_period(n);
        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        #1 slow_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_tick", {31'd0, tick1}, 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_count", 32'(count1), 32'h0000);
        check("midrst_flags", {29'd0, running1, done1, tick1}, 32'd0);
        slow_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;

        repeat (5) @(posedge clk);
        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_tick_timer.md
# bcd_tick_timer

Four-digit BCD up/down timer clocked by the system clock and advanced by the divided clock from the clock divider stage. The divided clock is treated as data: it is synchronized into `clk`, and each rising edge becomes a one-cycle tick. A start/stop/clear/load control FSM gates counting. The BCD count output feeds the seven-segment display driver. `done` flags terminal count to the buzzer/LED logic.

## Interface
- `TICKS_PER_STEP`, default 1: slow_clk rising edges per count step; legal range 1..255.
- `clk` in 1: system clock; all logic is on its rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `slow_clk` in 1: divided clock, asynchronous to logic here; sampled as data.
- `start` in 1: single-cycle request to begin or resume counting.
- `stop` in 1: single-cycle request to pause.
- `clear` in 1: single-cycle request to zero the count and return to idle.
- `load` in 1: single-cycle request to preset the count from `load_value`.
- `load_value` in 16: BCD preset as 4 digits, [15:12] most significant.
- `mode` in 1: 0 = count up, 1 = count down; sampled at each step.
- `count` out 16: current BCD count.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `tick` out 1: one-cycle pulse per detected slow_clk rising edge; debug aid.

## Operation
- Synchronizer and edge detect:
  - Two flops (`s1`, `s2`) synchronize `slow_clk`; a third flop `s3` holds the previous value.
  - `tick = s2 & ~s3`.
  - All three flops reset to 0.
- Prescaler:
  - 8-bit counter that advances on `tick` in RUN only.
  - When it reaches TICKS_PER_STEP-1 and `tick` is high, it produces `step` and returns to 0.
  - Held in PAUSE.
  - Zeroed by clear, load, and entry to RUN from IDLE.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - PAUSE --start--> RUN; prescaler is kept.
  - RUN --step reaching terminal--> DONE.
  - Any state --clear--> IDLE with count = 0000.
  - Any state --load--> IDLE with count = sanitized `load_value`.
  - DONE ignores start and stop; only clear or load exit it.
- Terminal values: up mode 9999, down mode 0000.
  - Start while count already equals the terminal value for the current `mode` goes directly to DONE; no step occurs.
- Control priority within one cycle: clear > load > stop > start > step.
  - Stop coincident with step: enter PAUSE; the step is discarded and the count is unchanged.
- BCD arithmetic: per-digit ripple.
  - Up: a digit equal to 9 becomes 0 and carries.
  - Down: a digit equal to 0 becomes 9 and borrows.
  - No wrap past a terminal, because reaching the terminal enters DONE.
- Load sanitize: any digit greater than 9 is replaced by 9.
- Mode change during RUN takes effect at the next step.
  - Terminal detection uses the mode sampled at that step.
- Reset values: count 0000, state IDLE, `running` 0, `done` 0, `tick` 0, prescaler 0.
- Reset mid-run aborts immediately and asynchronously to the values above.

## Timing
- slow_clk rising edge to `tick` high: 2–3 clk cycles (synchronizer uncertainty), then `tick` is high for exactly 1 cycle.
- `tick` (with prescaler at terminal) to `count` update: 1 cycle.
- The step that reaches the terminal updates `count` and sets `done` on the same clock edge.
- start, stop, clear, load take effect at the next clk edge; outputs change 1 cycle after the request cycle.
- `running` and `done` are registered, decoded from the state register; no combinational path from inputs.
- slow_clk high and low times must each be at least 2 clk periods. Narrower pulses may be missed.

## Test plan
- Reset, then hold `resetn` low mid-RUN:
  - Required: count 0000, `running` 0, `done` 0, `tick` 0 immediately.
- TICKS_PER_STEP=1, mode=0, slow_clk period 8 clk, start after load 0008:
  - Required: count goes 0009, 0010, 0011; one step per slow_clk rise.
  - Required: `tick` is 1 cycle wide.
- mode=1, load 0003, start:
  - Required: count 0002, 0001, 0000.
  - Required: `done` rises on the same edge as 0000; `running` drops to 0.
  - A further start leaves the FSM in DONE.
- TICKS_PER_STEP=3, start, then stop after 2 ticks, then start again:
  - Required: count does not change during PAUSE.
  - Required: the first step after resume occurs on the 1st tick, because the prescaler was kept.
- Same-cycle events:
  - stop together with step → PAUSE, count unchanged.
  - clear together with load → count 0000, IDLE.
- Load 0xA9F5 → count 9995. Up-mode start from 9999 → DONE with no step.
